// File: rtl/result_stage.sv
// Writeback result stage: ALU and load-data buffers with per-buffer valid flags,
// load lane extraction with sign/zero extension, and the register-file writeback mux.
module result_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_buf_we,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      addr_lsb,
  input  logic [2:0]      load_funct3,
  input  logic            data_buf_we,
  input  logic [XLEN-1:0] aux_src,
  input  logic            buf_clear,
  input  logic [1:0]      result_src,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            load_misaligned
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic [XLEN-1:0] alu_buf;
  logic [XLEN-1:0] data_buf;
  logic            alu_valid;
  logic            data_valid;

  logic [OFFW-1:0] off;
  logic [OFFW-1:0] half_off;
  logic [OFFW-1:0] word_off;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [31:0]     word_lane;
  logic [XLEN-1:0] ext_val;
  logic            lane_misaligned;
  logic            funct3_illegal;

  assign off      = addr_lsb[OFFW-1:0];
  // Misaligned accesses still read a lane: the offending low offset bits are dropped.
  assign half_off = off & ~OFFW'(1);
  assign word_off = off & ~OFFW'(3);

  generate
    if (OFFW < 3) begin : g_unused_lsb
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr_lsb[2:OFFW];
    end
  endgenerate

  always_comb begin
    byte_lane       = 8'(mem_rdata >> {off, 3'b000});
    half_lane       = 16'(mem_rdata >> {half_off, 3'b000});
    word_lane       = 32'(mem_rdata >> {word_off, 3'b000});
    ext_val         = '0;
    lane_misaligned = 1'b0;
    funct3_illegal  = 1'b0;
    case (load_funct3)
      3'b000: ext_val = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      3'b100: ext_val = {{(XLEN-8){1'b0}}, byte_lane};
      3'b001: begin
        ext_val         = {{(XLEN-16){half_lane[15]}}, half_lane};
        lane_misaligned = off[0];
      end
      3'b101: begin
        ext_val         = {{(XLEN-16){1'b0}}, half_lane};
        lane_misaligned = off[0];
      end
      3'b010: begin
        ext_val         = {XLEN{word_lane[31]}};
        ext_val[31:0]   = word_lane;
        lane_misaligned = (off[1:0] != 2'b00);
      end
      3'b110: begin
        if (XLEN == 64) begin
          ext_val[31:0]   = word_lane;
          lane_misaligned = (off[1:0] != 2'b00);
        end else begin
          funct3_illegal = 1'b1;
        end
      end
      3'b011: begin
        if (XLEN == 64) begin
          ext_val         = mem_rdata;
          lane_misaligned = (off != '0);
        end else begin
          funct3_illegal = 1'b1;
        end
      end
      default: funct3_illegal = 1'b1;
    endcase
  end

  // Write enables are applied after buf_clear so a same-cycle capture wins for its buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_buf         <= '0;
      data_buf        <= '0;
      alu_valid       <= 1'b0;
      data_valid      <= 1'b0;
      load_misaligned <= 1'b0;
    end else begin
      if (buf_clear) begin
        alu_valid  <= 1'b0;
        data_valid <= 1'b0;
      end
      if (alu_buf_we) begin
        alu_buf   <= alu_result;
        alu_valid <= 1'b1;
      end
      load_misaligned <= data_buf_we && !funct3_illegal && lane_misaligned;
      if (data_buf_we) begin
        if (funct3_illegal) begin
          data_buf   <= '0;
          data_valid <= 1'b0;
        end else begin
          data_buf   <= ext_val;
          data_valid <= !lane_misaligned;
        end
      end
    end
  end

  always_comb begin
    result       = alu_buf;
    result_valid = alu_valid;
    case (result_src)
      2'b00: begin
        result       = alu_buf;
        result_valid = alu_valid;
      end
      2'b01: begin
        result       = data_buf;
        result_valid = data_valid;
      end
      2'b10: begin
        result       = alu_result;
        result_valid = 1'b1;
      end
      default: begin
        result       = aux_src;
        result_valid = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_result_stage.sv
// Directed bench for result_stage: a 32-bit and a 64-bit instance share control
// inputs; each scenario task drives vectors and compares against hand-computed values.
module tb_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_buf_we;
  logic        data_buf_we;
  logic        buf_clear;
  logic [2:0]  addr_lsb;
  logic [2:0]  load_funct3;
  logic [1:0]  result_src;

  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] aux_src;
  logic [31:0] result;
  logic        result_valid;
  logic        load_misaligned;

  logic [63:0] alu_result64;
  logic [63:0] mem_rdata64;
  logic [63:0] aux_src64;
  logic [63:0] result64;
  logic        result_valid64;
  logic        load_misaligned64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alu_result(alu_result), .alu_buf_we(alu_buf_we),
    .mem_rdata(mem_rdata), .addr_lsb(addr_lsb), .load_funct3(load_funct3),
    .data_buf_we(data_buf_we), .aux_src(aux_src), .buf_clear(buf_clear),
    .result_src(result_src), .result(result), .result_valid(result_valid),
    .load_misaligned(load_misaligned)
  );

  result_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst),
    .alu_result(alu_result64), .alu_buf_we(alu_buf_we),
    .mem_rdata(mem_rdata64), .addr_lsb(addr_lsb), .load_funct3(load_funct3),
    .data_buf_we(data_buf_we), .aux_src(aux_src64), .buf_clear(buf_clear),
    .result_src(result_src), .result(result64), .result_valid(result_valid64),
    .load_misaligned(load_misaligned64)
  );

  // Extension vectors for mem_rdata = 0x80F17F85
  logic [2:0]  ext_f3  [8] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010, 3'b000, 3'b101};
  logic [2:0]  ext_off [8] = '{3'd0,   3'd0,   3'd1,   3'd2,   3'd2,   3'd0,   3'd3,   3'd0};
  logic [31:0] ext_exp [8] = '{32'hFFFFFF85, 32'h00000085, 32'h0000007F, 32'hFFFF80F1,
                               32'h000080F1, 32'h80F17F85, 32'hFFFFFF80, 32'h00007F85};

  // Vectors for mem_rdata64 = 0x8000000180000002
  logic [2:0]  x64_f3  [6] = '{3'b010, 3'b110, 3'b011, 3'b010, 3'b000, 3'b101};
  logic [2:0]  x64_off [6] = '{3'd4,   3'd4,   3'd0,   3'd0,   3'd7,   3'd6};
  logic [63:0] x64_exp [6] = '{64'hFFFFFFFF80000001, 64'h0000000080000001, 64'h8000000180000002,
                               64'hFFFFFFFF80000002, 64'hFFFFFFFFFFFFFF80, 64'h0000000000008000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_capture(input logic [2:0] f3, input logic [2:0] off);
    load_funct3 = f3;
    addr_lsb    = off;
    data_buf_we = 1'b1;
    step();
    data_buf_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_buf_we = 1'b1;
    alu_result = 32'hDEADBEEF;
    alu_result64 = 64'hDEADBEEF;
    step();
    step();
    rst = 1'b0;
    alu_buf_we = 1'b0;
    result_src = 2'b00;
    #1;
    checks++;
    if (result !== 32'h0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_alu result=%h valid=%b expected=00000000 valid=0", result, result_valid);
    end
    checks++;
    if (load_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_misaligned got=%b expected=0", load_misaligned);
    end
    result_src = 2'b01;
    #1;
    checks++;
    if (result !== 32'h0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_data result=%h valid=%b expected=00000000 valid=0", result, result_valid);
    end
  endtask

  task automatic test_live();
    result_src = 2'b10;
    alu_result = 32'hAAAA5555;
    #1;
    checks++;
    if (result !== 32'hAAAA5555 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL live_alu0 result=%h valid=%b expected=aaaa5555 valid=1", result, result_valid);
    end
    alu_result = 32'h0F0F1234;
    #1;
    checks++;
    if (result !== 32'h0F0F1234 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL live_alu1 result=%h valid=%b expected=0f0f1234 valid=1", result, result_valid);
    end
    result_src = 2'b11;
    aux_src = 32'h00401004;
    #1;
    checks++;
    if (result !== 32'h00401004 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL live_aux0 result=%h valid=%b expected=00401004 valid=1", result, result_valid);
    end
    aux_src = 32'hCAFE0000;
    #1;
    checks++;
    if (result !== 32'hCAFE0000 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL live_aux1 result=%h valid=%b expected=cafe0000 valid=1", result, result_valid);
    end
  endtask

  task automatic test_extension();
    mem_rdata  = 32'h80F17F85;
    result_src = 2'b01;
    for (int i = 0; i < 8; i++) begin
      load_capture(ext_f3[i], ext_off[i]);
      checks++;
      if (result !== ext_exp[i] || result_valid !== 1'b1 || load_misaligned !== 1'b0) begin
        failures++;
        $display("FAIL ext_%0d result=%h valid=%b mis=%b expected=%h valid=1 mis=0",
                 i, result, result_valid, load_misaligned, ext_exp[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    mem_rdata  = 32'h80F17F85;
    result_src = 2'b01;
    load_capture(3'b010, 3'd2);
    checks++;
    if (load_misaligned !== 1'b1 || result_valid !== 1'b0 || result !== 32'h80F17F85) begin
      failures++;
      $display("FAIL mis_lw result=%h valid=%b mis=%b expected=80f17f85 valid=0 mis=1",
               result, result_valid, load_misaligned);
    end
    step();
    checks++;
    if (load_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL mis_pulse_len got=%b expected=0", load_misaligned);
    end
    load_capture(3'b001, 3'd3);
    checks++;
    if (load_misaligned !== 1'b1 || result_valid !== 1'b0 || result !== 32'hFFFF80F1) begin
      failures++;
      $display("FAIL mis_lh result=%h valid=%b mis=%b expected=ffff80f1 valid=0 mis=1",
               result, result_valid, load_misaligned);
    end
    // A second misaligned capture right behind keeps the pulse high
    load_capture(3'b101, 3'd1);
    checks++;
    if (load_misaligned !== 1'b1 || result !== 32'h00007F85) begin
      failures++;
      $display("FAIL mis_b2b result=%h mis=%b expected=00007f85 mis=1", result, load_misaligned);
    end
    load_capture(3'b010, 3'd0);
    checks++;
    if (load_misaligned !== 1'b0 || result_valid !== 1'b1 || result !== 32'h80F17F85) begin
      failures++;
      $display("FAIL mis_recover result=%h valid=%b mis=%b expected=80f17f85 valid=1 mis=0",
               result, result_valid, load_misaligned);
    end
  endtask

  task automatic test_illegal();
    mem_rdata  = 32'h80F17F85;
    result_src = 2'b01;
    load_capture(3'b111, 3'd0);
    checks++;
    if (result !== 32'h0 || result_valid !== 1'b0 || load_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL illegal_111 result=%h valid=%b mis=%b expected=00000000 valid=0 mis=0",
               result, result_valid, load_misaligned);
    end
    load_capture(3'b000, 3'd0);
    load_capture(3'b011, 3'd1);
    checks++;
    if (result !== 32'h0 || result_valid !== 1'b0 || load_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL illegal_ld32 result=%h valid=%b mis=%b expected=00000000 valid=0 mis=0",
               result, result_valid, load_misaligned);
    end
    load_capture(3'b000, 3'd0);
    load_capture(3'b110, 3'd0);
    checks++;
    if (result !== 32'h0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_lwu32 result=%h valid=%b expected=00000000 valid=0", result, result_valid);
    end
  endtask

  task automatic test_clear_vs_write();
    mem_rdata  = 32'h80F17F85;
    alu_result = 32'h11112222;
    alu_buf_we = 1'b1;
    load_capture(3'b100, 3'd0);
    alu_buf_we = 1'b0;
    buf_clear  = 1'b1;
    alu_buf_we = 1'b1;
    alu_result = 32'h12345678;
    step();
    buf_clear  = 1'b0;
    alu_buf_we = 1'b0;
    alu_result = 32'h0;
    result_src = 2'b00;
    #1;
    checks++;
    if (result !== 32'h12345678 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_alu_wins result=%h valid=%b expected=12345678 valid=1", result, result_valid);
    end
    result_src = 2'b01;
    #1;
    checks++;
    if (result !== 32'h00000085 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_data result=%h valid=%b expected=00000085 valid=0", result, result_valid);
    end
    buf_clear = 1'b1;
    step();
    buf_clear  = 1'b0;
    result_src = 2'b00;
    #1;
    checks++;
    if (result !== 32'h12345678 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_alu_hold result=%h valid=%b expected=12345678 valid=0", result, result_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'h00000001, 32'hFFFF0000, 32'h7FFFFFFF};
    result_src = 2'b00;
    alu_buf_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_result = vals[i];
      step();
      checks++;
      if (result !== vals[i] || result_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d result=%h valid=%b expected=%h valid=1", i, result, result_valid, vals[i]);
      end
    end
    alu_buf_we = 1'b0;
    alu_result = 32'h0;
    step();
    checks++;
    if (result !== 32'h7FFFFFFF) begin
      failures++;
      $display("FAIL b2b_hold result=%h expected=7fffffff", result);
    end
  endtask

  task automatic test_xlen64();
    mem_rdata64 = 64'h8000000180000002;
    result_src  = 2'b01;
    for (int i = 0; i < 6; i++) begin
      load_capture(x64_f3[i], x64_off[i]);
      checks++;
      if (result64 !== x64_exp[i] || result_valid64 !== 1'b1 || load_misaligned64 !== 1'b0) begin
        failures++;
        $display("FAIL x64_%0d result=%h valid=%b mis=%b expected=%h valid=1 mis=0",
                 i, result64, result_valid64, load_misaligned64, x64_exp[i]);
      end
    end
    load_capture(3'b011, 3'd4);
    checks++;
    if (result64 !== 64'h8000000180000002 || result_valid64 !== 1'b0 || load_misaligned64 !== 1'b1) begin
      failures++;
      $display("FAIL x64_ld_mis result=%h valid=%b mis=%b expected=8000000180000002 valid=0 mis=1",
               result64, result_valid64, load_misaligned64);
    end
    load_capture(3'b110, 3'd2);
    checks++;
    if (result64 !== 64'h0000000080000002 || result_valid64 !== 1'b0 || load_misaligned64 !== 1'b1) begin
      failures++;
      $display("FAIL x64_lwu_mis result=%h valid=%b mis=%b expected=0000000080000002 valid=0 mis=1",
               result64, result_valid64, load_misaligned64);
    end
  endtask

  initial begin
    rst          = 1'b1;
    alu_buf_we   = 1'b0;
    data_buf_we  = 1'b0;
    buf_clear    = 1'b0;
    addr_lsb     = 3'd0;
    load_funct3  = 3'b000;
    result_src   = 2'b00;
    alu_result   = 32'h0;
    mem_rdata    = 32'h0;
    aux_src      = 32'h0;
    alu_result64 = 64'h0;
    mem_rdata64  = 64'h0;
    aux_src64    = 64'h0;

    test_reset();
    test_live();
    test_extension();
    test_misaligned();
    test_illegal();
    test_clear_vs_write();
    test_back_to_back();
    test_xlen64();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_stage.md
# result_stage

Parametrised writeback-result stage for the multicycle core: owns the ALU-result and memory-data buffer registers, performs load byte/halfword/word extraction with sign or zero extension at capture time, and selects the value written back to the register file. It sits between the ALU and data-memory read port and the register-file write port. Per-buffer valid tracking and a registered misalignment flag are provided to the control FSM.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- alu_result  input  XLEN  live ALU output.
- alu_buf_we  input  1  capture alu_result into the ALU buffer.
- mem_rdata  input  XLEN  raw data-memory read word, naturally aligned.
- addr_lsb  input  3  low address bits of the load; only [log2(XLEN/8)-1:0] used.
- load_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 011 LD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
- data_buf_we  input  1  capture extracted load value into the data buffer.
- aux_src  input  XLEN  live auxiliary source (PC+4 / upper immediate).
- buf_clear  input  1  clear both valid flags.
- result_src  input  2  00 ALU buffer, 01 data buffer, 10 live ALU, 11 aux.
- result  output  XLEN  selected writeback value.
- result_valid  output  1  selected source holds valid data.
- load_misaligned  output  1  registered one-cycle pulse for a misaligned load capture.

## Operation
- ALU buffer: on clk with alu_buf_we=1, alu_buf <= alu_result, alu_valid <= 1.
- Data buffer: on clk with data_buf_we=1, data_buf <= extract(mem_rdata, addr_lsb, load_funct3), data_valid <= 1.
- Extraction: byte lane = mem_rdata[8*off +: 8] with off = addr_lsb mod (XLEN/8); half lane at off (off must be even); word lane at off (off multiple of 4); LD takes the whole word. Signed types replicate the lane MSB to XLEN; unsigned types zero-fill.
- Misalignment: LH/LHU with off[0]=1, or LW/LWU with off[1:0]≠0, or LD with off≠0, while data_buf_we=1. The next cycle has load_misaligned=1 for exactly one cycle. data_buf still captures the extracted value, using the lane with the offending low bits forced to 0. data_valid is not set.
- Illegal funct3 (111, or 011/110 with XLEN=32) with data_buf_we=1: data_buf <= 0, data_valid <= 0, no misaligned pulse.
- buf_clear=1: alu_valid <= 0, data_valid <= 0. A write enable in the same cycle takes priority for its own buffer: that buffer captures and its valid is 1.
- Mux (combinational): result_src 00 → alu_buf / alu_valid; 01 → data_buf / data_valid; 10 → alu_result / 1; 11 → aux_src / 1.
- Buffers hold their value indefinitely when not written. Valid flags are only cleared by buf_clear, a misaligned or illegal capture (data_valid only), or rst.

## Timing
- Reset (clk edge with rst=1): alu_buf=0, data_buf=0, alu_valid=0, data_valid=0, load_misaligned=0. result therefore reads 0 for sources 00/01.
- rst has priority over all enables and clears. A capture in progress is discarded.
- Capture latency is one cycle: data written at edge N is visible on result at N+ (same-cycle combinational after the edge).
- Live sources 10/11 have zero latency; there is no register between input and result.
- load_misaligned is asserted the cycle after the capturing edge and deasserted one cycle later unless a new misaligned capture occurs.
- Back-to-back captures every cycle are supported; each overwrites the previous value.

## Test plan
- Reset: assert rst 2 cycles with alu_buf_we=1, alu_result=0xDEADBEEF → alu_buf=0, result_valid=0 at result_src=00, load_misaligned=0.
- Sign/zero extension (XLEN=32): mem_rdata=0x80F17F85, data_buf_we=1. LB off=0 → 0xFFFFFF85; LBU off=0 → 0x00000085; LB off=1 → 0x0000007F; LH off=2 → 0xFFFF80F1; LHU off=2 → 0x000080F1; LW off=0 → 0x80F17F85. Each has result_valid=1 at result_src=01.
- Misaligned: LW with off=2 → load_misaligned=1 for exactly one cycle after capture, data_valid=0. LH with off=3 → data_buf=0xFFFF80F1 (lane 2), pulse asserted.
- Clear vs write: buf_clear=1 and alu_buf_we=1 with alu_result=0x12345678 in the same cycle → alu_valid=1, alu_buf=0x12345678, data_valid=0.
- Live sources: result_src=10 and 11 track alu_result/aux_src changes within the same cycle with result_valid=1 even immediately after reset.
- XLEN=64: mem_rdata=0x8000000180000002. LW off=4 → 0xFFFFFFFF80000001; LWU off=4 → 0x0000000080000001; LD off=0 → full word; LD with XLEN=32 gives illegal behaviour (data_buf=0, data_valid=0).
